// File: rtl/hps_pio_bidir_if.sv
// Avalon-MM slave bus bundle for the HPS PIO block.
interface hps_pio_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hps_pio_bidir.sv
// Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear, synchronised
// inputs with armed edge capture and a masked level interrupt.
module hps_pio_bidir #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  hps_pio_bidir_if.slave    bus,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic [WIDTH-1:0]  oe,
  output logic              irq
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_EDGE = 3'd3;
  localparam logic [2:0] A_SET  = 3'd4;
  localparam logic [2:0] A_CLR  = 3'd5;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] wd;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             wr;
  logic             unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt == ARM_W'(ARM_MAX));

  // Input synchroniser, edge history and post-reset arming counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_sync;
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  // Edge detect restricted to input bits, suppressed until the chain has settled
  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = in_sync & ~prev_q;
      1:       edge_raw = ~in_sync & prev_q;
      default: edge_raw = in_sync ^ prev_q;
    endcase
    edge_det = edge_raw & ~oe & {WIDTH{armed}};
  end

  assign w1c = (wr && bus.address == A_EDGE) ? wd : '0;

  // Control registers; a new edge overrides a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port    <= RESET_VALUE;
      oe          <= DIR_RESET;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~w1c) | edge_det;
      if (wr) begin
        case (bus.address)
          A_DATA:  out_port <= wd;
          A_DIR:   oe       <= wd;
          A_MASK:  irqmask  <= wd;
          A_SET:   out_port <= out_port | wd;
          A_CLR:   out_port <= out_port & ~wd;
          default: ;
        endcase
      end
    end
  end

  assign irq = |(edgecapture & irqmask);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      A_DATA:  bus.readdata = 32'((oe & out_port) | (~oe & in_sync));
      A_DIR:   bus.readdata = 32'(oe);
      A_MASK:  bus.readdata = 32'(irqmask);
      A_EDGE:  bus.readdata = 32'(edgecapture);
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hps_pio_bidir.sv
// Directed bench for hps_pio_bidir: 8-bit, 32-bit and 5-bit instances.
module tb_hps_pio_bidir;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic [7:0]  in8  = '0;
  logic [7:0]  out8, oe8;
  logic        irq8;
  logic [31:0] in32 = '0;
  logic [31:0] out32, oe32;
  logic        irq32;
  logic [4:0]  in5  = '0;
  logic [4:0]  out5, oe5;
  logic        irq5;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] rd;

  hps_pio_bidir_if bus8 ();
  hps_pio_bidir_if bus32 ();
  hps_pio_bidir_if bus5 ();

  always #5 clk = ~clk;

  hps_pio_bidir #(.WIDTH(8), .RESET_VALUE(8'hA5), .DIR_RESET(8'hF0),
                  .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8.slave),
    .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8));

  hps_pio_bidir #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .bus(bus32.slave),
    .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32));

  hps_pio_bidir #(.WIDTH(5)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .bus(bus5.slave),
    .in_port(in5), .out_port(out5), .oe(oe5), .irq(irq5));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int which, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] d);
    case (which)
      8: begin bus8.chipselect = cs; bus8.write_n = wn; bus8.address = a; bus8.writedata = d; end
      32: begin bus32.chipselect = cs; bus32.write_n = wn; bus32.address = a; bus32.writedata = d; end
      default: begin bus5.chipselect = cs; bus5.write_n = wn; bus5.address = a; bus5.writedata = d; end
    endcase
  endtask

  // One write, committed on the next rising edge
  task automatic wr(input int which, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(which, 1'b1, 1'b0, a, d);
    @(posedge clk);
    #1 drive(which, 1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  // Combinational read within the current low phase
  task automatic rd_now(input int which, input logic [2:0] a, output logic [31:0] d);
    drive(which, 1'b1, 1'b1, a, 32'd0);
    #1;
    case (which)
      8:       d = bus8.readdata;
      32:      d = bus32.readdata;
      default: d = bus5.readdata;
    endcase
    drive(which, 1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive(8, 1'b0, 1'b1, 3'd0, 32'd0);
    drive(32, 1'b0, 1'b1, 3'd0, 32'd0);
    drive(5, 1'b0, 1'b1, 3'd0, 32'd0);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_port", 32'(out8), 32'h0000_00A5);
    check("rst_oe", 32'(oe8), 32'h0000_00F0);
    check("rst_irq", 32'(irq8), 32'd0);
    rd_now(8, 3'd1, rd);
    check("rst_rd_dir", rd, 32'h0000_00F0);
    reset_n = 1'b1;
    cycles(5);

    // Atomic set/clear
    wr(8, 3'd0, 32'h0000_0000);
    wr(8, 3'd4, 32'h0000_000F);
    wr(8, 3'd5, 32'h0000_0081);
    @(negedge clk);
    check("setclr_out_port", 32'(out8), 32'h0000_000E);
    rd_now(8, 3'd4, rd);
    check("rd_set_zero", rd, 32'd0);

    // Rising edge latency and interrupt
    wr(8, 3'd1, 32'h0000_0000);
    wr(8, 3'd2, 32'h0000_0004);
    @(negedge clk);
    in8 = 8'h04;
    cycles(1);
    rd_now(8, 3'd3, rd);
    check("edge_after1", rd, 32'd0);
    cycles(1);
    rd_now(8, 3'd3, rd);
    check("edge_after2", rd, 32'd0);
    check("irq_after2", 32'(irq8), 32'd0);
    cycles(1);
    rd_now(8, 3'd3, rd);
    check("edge_after3", rd, 32'h0000_0004);
    check("irq_after3", 32'(irq8), 32'd1);

    // W1C clears capture and interrupt
    wr(8, 3'd3, 32'h0000_0004);
    @(negedge clk);
    rd_now(8, 3'd3, rd);
    check("w1c_edge", rd, 32'd0);
    check("w1c_irq", 32'(irq8), 32'd0);

    // Falling edge ignored in rising mode
    in8 = 8'h00;
    cycles(5);
    rd_now(8, 3'd3, rd);
    check("fall_ignored", rd, 32'd0);

    // Edge coincident with W1C: set wins
    in8 = 8'h04;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 3'd3, 32'h0000_0004);
    @(posedge clk);
    #1 drive(8, 1'b0, 1'b1, 3'd0, 32'd0);
    @(negedge clk);
    rd_now(8, 3'd3, rd);
    check("set_wins", rd, 32'h0000_0004);

    // Output bit never captures; DATA read mixes out_port and in_sync
    wr(8, 3'd1, 32'h0000_0008);
    @(negedge clk);
    in8 = 8'h0C;
    cycles(5);
    rd_now(8, 3'd3, rd);
    check("out_bit_no_cap", rd, 32'h0000_0004);
    in8 = 8'h04;
    cycles(4);
    rd_now(8, 3'd0, rd);
    check("data_mix", rd, 32'h0000_000C);

    // Pin high through reset release: no spurious capture
    in8 = 8'hFF;
    cycles(3);
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(8);
    rd_now(8, 3'd3, rd);
    check("no_spurious", rd, 32'd0);
    check("rerst_out_port", 32'(out8), 32'h0000_00A5);

    // Full-width instance
    wr(32, 3'd0, 32'hDEAD_BEEF);
    wr(32, 3'd1, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_now(32, 3'd0, rd);
    check("w32_data", rd, 32'hDEAD_BEEF);

    // Narrow instance: upper bits dropped
    wr(5, 3'd0, 32'hDEAD_BEEF);
    wr(5, 3'd1, 32'hFFFF_FFFF);
    wr(5, 3'd2, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_now(5, 3'd0, rd);
    check("w5_data", rd, 32'h0000_000F);
    rd_now(5, 3'd2, rd);
    check("w5_mask", rd, 32'h0000_001F);
    rd_now(5, 3'd6, rd);
    check("w5_addr6", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
